evaluate_window: RTL and testbench
==================================

// Module: evaluate_window
// PURPOSE
//   Parametrised successor to the scoring evaluator. Compares a reference (base) sample
//   stream with a sung (test) stream over a window of NUM_SAMPLES valid samples.
//   Counts per-sample hits within a tolerance and reports a hit score, the worst error
//   and a pass/fail verdict. Sits in the scoring path between the pitch/amplitude
//   extractors and the score display/UI controller.
// PARAMETERS
//   WIDTH       16   signed sample width of i_signal_base / i_signal_test
//   NUM_SAMPLES 256  valid samples per evaluation window (>=1)
//   PASS_COUNT  192  minimum hits for o_result=1 (0..NUM_SAMPLES)
//   REL_SHIFT   3    relative-mode tolerance = |base| >> REL_SHIFT
// PORTS  (SW = $clog2(NUM_SAMPLES+1))
//   i_clk          in   1       clock, rising edge
//   i_rst_n        in   1       asynchronous active-low reset
//   i_start        in   1       start a window (accepted only in IDLE)
//   i_abort        in   1       cancel the window in progress, no o_finish
//   i_mode         in   1       0 = absolute tolerance, 1 = relative tolerance; latched on start
//   i_tolerance    in   WIDTH   unsigned absolute tolerance (mode 0); latched on start
//   i_valid        in   1       sample strobe for base/test
//   i_signal_base  in   WIDTH   signed reference sample
//   i_signal_test  in   WIDTH   signed test sample
//   o_busy         out  1       high in RUN and FLUSH
//   o_finish       out  1       one-cycle pulse, results valid
//   o_result       out  1       score >= PASS_COUNT
//   o_score        out  SW      hit count of the last completed window
//   o_max_err      out  WIDTH+1 largest |base-test| in the last completed window
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters/accumulators 0. Reset mid-window discards it.
//   FSM: IDLE -> RUN on i_start. RUN -> FLUSH on the cycle the NUM_SAMPLES-th valid is taken.
//     FLUSH -> DONE (1 cycle). DONE -> IDLE (1 cycle, o_finish=1).
//     i_abort in RUN/FLUSH -> IDLE next cycle; outputs keep previous window values; no pulse.
//     i_abort has priority over sample acceptance in the same cycle. Ignored in IDLE/DONE.
//   Start: i_mode/i_tolerance are latched. Sample count, hit and max-error accumulators
//     are cleared. i_start in RUN/FLUSH/DONE is ignored. i_valid in the start cycle is ignored.
//   Stage 1 (cycle after valid): diff = sign-extended (base - test) to WIDTH+1 bits, and
//     |diff| is registered. tol = mode0 ? i_tolerance : (|base| >> REL_SHIFT); |base| uses
//     WIDTH+1 bits, so base = -2^(WIDTH-1) has no overflow.
//   Stage 2: hit = |diff| <= tol. hit_cnt += hit. max_err = max(max_err, |diff|).
//   Latency: o_finish is asserted 3 cycles after the cycle accepting the last valid.
//     o_score, o_result and o_max_err update in the same cycle as o_finish and hold
//     until the next o_finish or reset.
//   Valid gaps are allowed: the window counts valid samples, not cycles.
//     i_valid in FLUSH/DONE/IDLE is dropped.
//   hit_cnt saturates structurally: the maximum is NUM_SAMPLES, which fits SW bits.
//   Relative mode with base=0: tol=0, so only exact matches hit.
// TESTING
//   1 mode0 tol=0, base=test=100, valid every cycle -> o_finish 3 cycles after the 256th
//     valid; score=256, result=1, max_err=0.
//   2 mode0 tol=5, base=100, test=110 -> score=0, result=0, max_err=10.
//     Same stimulus with tol=10 -> score=256.
//   3 mode1, base=-800, test=-880 (tol=100) -> score=256.
//     base=800, test=910 -> score=0, max_err=110.
//   4 base=32767, test=-32768 -> max_err=65535 (17-bit, no wrap).
//     192 hits + 64 misses -> result=1; 191 hits -> result=0.
//   5 valid every 2nd cycle -> o_finish after 256 valids (~512 cycles).
//     i_start pulsed mid-run -> ignored, count continues.
//   6 i_abort after 100 samples -> no o_finish, outputs unchanged.
//     i_rst_n low mid-run -> outputs 0. A new start -> full fresh 256-sample window.

Source files
------------

// File: rtl/evaluate_window.sv
// evaluate_window: windowed base/test sample comparison producing hit score, worst error and verdict
module evaluate_window #(
  parameter int WIDTH       = 16,
  parameter int NUM_SAMPLES = 256,
  parameter int PASS_COUNT  = 192,
  parameter int REL_SHIFT   = 3,
  localparam int SW         = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_tolerance,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_signal_base,
  input  logic [WIDTH-1:0] i_signal_test,
  output logic             o_busy,
  output logic             o_finish,
  output logic             o_result,
  output logic [SW-1:0]    o_score,
  output logic [WIDTH:0]   o_max_err
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t           r_state, w_next;
  logic             r_mode;
  logic [WIDTH-1:0] r_tol;
  logic [SW-1:0]    r_cnt, r_hits;
  logic [WIDTH:0]   r_max_err, r_s1_abs, r_s1_tol;
  logic             r_s1_valid;
  logic             w_start, w_accept, w_last;
  logic [WIDTH:0]   w_base_x, w_diff, w_abs_diff, w_abs_base, w_tol;
  assign w_start    = (r_state == S_IDLE) && i_start;
  assign w_accept   = (r_state == S_RUN) && i_valid && !i_abort;
  assign w_last     = w_accept && (r_cnt == SW'(NUM_SAMPLES - 1));
  assign w_base_x   = {i_signal_base[WIDTH-1], i_signal_base};
  assign w_diff     = w_base_x - {i_signal_test[WIDTH-1], i_signal_test};
  assign w_abs_diff = w_diff[WIDTH] ? -w_diff : w_diff;
  assign w_abs_base = w_base_x[WIDTH] ? -w_base_x : w_base_x;
  assign w_tol      = r_mode ? (w_abs_base >> REL_SHIFT) : {1'b0, r_tol};
  // next-state and busy decode; abort pulls RUN/FLUSH straight back to IDLE
  always_comb begin
    w_next = r_state;
    o_busy = (r_state == S_RUN) || (r_state == S_FLUSH);
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = i_abort ? S_IDLE : (w_last ? S_FLUSH : S_RUN);
      S_FLUSH: w_next = i_abort ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end
  // two-stage datapath: stage 1 registers |diff| and tolerance, stage 2 accumulates
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode     <= 1'b0;
      r_tol      <= '0;
      r_cnt      <= '0;
      r_hits     <= '0;
      r_max_err  <= '0;
      r_s1_valid <= 1'b0;
      r_s1_abs   <= '0;
      r_s1_tol   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_cnt    <= r_cnt + 1'b1;
        r_s1_abs <= w_abs_diff;
        r_s1_tol <= w_tol;
      end
      if (w_start) begin
        r_mode    <= i_mode;
        r_tol     <= i_tolerance;
        r_cnt     <= '0;
        r_hits    <= '0;
        r_max_err <= '0;
      end else if (r_s1_valid) begin
        r_hits    <= r_hits + SW'(r_s1_abs <= r_s1_tol);
        r_max_err <= (r_s1_abs > r_max_err) ? r_s1_abs : r_max_err;
      end
    end
  end
  // publish results on leaving DONE; they hold until the next completed window
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_finish  <= 1'b0;
      o_result  <= 1'b0;
      o_score   <= '0;
      o_max_err <= '0;
    end else begin
      o_finish <= (r_state == S_DONE);
      if (r_state == S_DONE) begin
        o_score   <= r_hits;
        o_max_err <= r_max_err;
        o_result  <= (r_hits >= SW'(PASS_COUNT));
      end
    end
  end
endmodule

// File: tb/tb_evaluate_window.sv
// tb_evaluate_window: directed windows checked against a per-window arithmetic model every cycle
module tb_evaluate_window;
  localparam int N = 256;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, mode = 0, valid = 0;
  logic [15:0] tol = 0;
  logic signed [15:0] base = 0, test = 0;
  logic busy, finish, result;
  logic [8:0] score;
  logic [16:0] max_err;
  int vectors = 0, miscompares = 0;
  bit m_run, m_mode;
  int m_pend, m_n, m_hits, m_max, m_tol;
  bit e_finish, e_result;
  int e_score, e_max;
  always #5 clk = ~clk;
  evaluate_window dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
    .i_tolerance(tol), .i_valid(valid), .i_signal_base(base), .i_signal_test(test),
    .o_busy(busy), .o_finish(finish), .o_result(result), .o_score(score), .o_max_err(max_err)
  );
  task automatic cmp(string name, int act, int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // window model: counts samples, scores them arithmetically, releases results 3 cycles after the last one
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_pend = 0; e_finish = 0; e_result = 0; e_score = 0; e_max = 0;
    end else begin
      e_finish = 0;
      if (abort && (m_run || m_pend == 2)) begin
        m_run = 0; m_pend = 0;
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          e_finish = 1; e_score = m_hits; e_max = m_max; e_result = m_hits >= 192;
        end
      end else if (m_run) begin
        if (valid) begin
          int b, t, d, ad, ab, th;
          b = base; t = test; d = b - t;
          ad = d < 0 ? -d : d;
          ab = b < 0 ? -b : b;
          th = m_mode ? ab / 8 : m_tol;
          if (ad <= th) m_hits++;
          if (ad > m_max) m_max = ad;
          m_n++;
          if (m_n == N) begin m_run = 0; m_pend = 2; end
        end
      end else if (start) begin
        m_run = 1; m_n = 0; m_hits = 0; m_max = 0; m_mode = mode; m_tol = int'(tol);
      end
    end
  end
  always @(negedge clk) begin
    cmp("busy", busy, int'(m_run || m_pend == 2));
    cmp("finish", finish, e_finish);
    cmp("result", result, e_result);
    cmp("score", score, e_score);
    cmp("max_err", max_err, e_max);
  end
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic window(bit m, int tl, int b, int th, int tm, int nh, bit gap, bit mid_start);
    int k;
    start = 1; mode = m; tol = 16'(tl); valid = 1; base = 16'(b); test = 16'(th);
    step();
    start = 0; mode = !m; tol = 16'(~tl);
    for (int i = 0; i < N; i++) begin
      valid = 1; base = 16'(b); test = 16'(i < nh ? th : tm);
      start = mid_start && i == 100;
      step();
      start = 0;
      if (gap) begin valid = 0; step(); end
    end
    valid = 0;
    k = 0;
    while (!finish && k < 10) begin step(); k++; end
    cmp("latency", k, gap ? 1 : 2);
    repeat (3) step();
  endtask
  task automatic lit(string name, int s, int r, int me);
    cmp({name, "_score"}, score, s);
    cmp({name, "_result"}, result, r);
    cmp({name, "_max_err"}, max_err, me);
    cmp({name, "_model_score"}, e_score, s);
    cmp({name, "_model_max"}, e_max, me);
  endtask
  initial begin
    repeat (2) step();
    rst_n = 1;
    step();
    lit("reset", 0, 0, 0);
    cmp("reset_busy", busy, 0);
    window(0, 0, 100, 100, 100, N, 0, 0);         lit("t1", 256, 1, 0);
    window(0, 5, 100, 110, 110, 0, 0, 0);         lit("t2a", 0, 0, 10);
    window(0, 10, 100, 110, 110, N, 0, 0);        lit("t2b", 256, 1, 10);
    window(1, 0, -800, -880, -880, N, 0, 0);      lit("t3a", 256, 1, 80);
    window(1, 0, 800, 910, 910, 0, 0, 0);         lit("t3b", 0, 0, 110);
    window(0, 0, 32767, -32768, -32768, 0, 0, 0); lit("t4a", 0, 0, 65535);
    window(0, 5, 100, 100, 110, 192, 0, 0);       lit("t4b", 192, 1, 10);
    window(0, 5, 100, 100, 110, 191, 0, 0);       lit("t4c", 191, 0, 10);
    start = 1; mode = 0; tol = 0; step(); start = 0;
    for (int i = 0; i < 100; i++) begin valid = 1; base = 7; test = 7; step(); end
    abort = 1; step(); abort = 0; valid = 0;
    cmp("abort_busy", busy, 0);
    repeat (300) step();
    lit("abort", 191, 0, 10);
    window(0, 0, 100, 100, 100, N, 1, 1);         lit("t5", 256, 1, 0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 50; i++) begin valid = 1; base = 1; test = 9; step(); end
    rst_n = 0; valid = 0; step(); rst_n = 1; step();
    lit("midreset", 0, 0, 0);
    window(0, 3, -5, -3, -3, N, 0, 0);            lit("fresh", 256, 1, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
